// File: rtl/regfile_sb_if.sv
// Register-file bus: two write ports, issue strobe, NRD read ports and the pending vector.
interface regfile_sb_if #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2
);
    localparam int AW = $clog2(NREGS);

    logic                  WEN0;
    logic [AW-1:0]         wsel0;
    logic [DWIDTH-1:0]     wdat0;
    logic                  WEN1;
    logic [AW-1:0]         wsel1;
    logic [DWIDTH-1:0]     wdat1;
    logic                  iss;
    logic [AW-1:0]         isel;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DWIDTH-1:0] rdat;
    logic [NRD-1:0]        rbusy;
    logic [NREGS-1:0]      pend;

    modport master (
        output WEN0, wsel0, wdat0, WEN1, wsel1, wdat1, iss, isel, rsel,
        input  rdat, rbusy, pend
    );

    modport slave (
        input  WEN0, wsel0, wdat0, WEN1, wsel1, wdat1, iss, isel, rsel,
        output rdat, rbusy, pend
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with a per-register pending scoreboard.
// Register 0 is hard-wired to zero and can never be pending.
module regfile_sb_rdport #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                          i_rst_n,
    input  logic [NREGS-1:0][DWIDTH-1:0]  i_regs,
    input  logic [NREGS-1:0]              i_pend,
    input  logic [AW-1:0]                 i_rsel,
    input  logic                          i_we0,
    input  logic [AW-1:0]                 i_wsel0,
    input  logic [DWIDTH-1:0]             i_wdat0,
    input  logic                          i_we1,
    input  logic [AW-1:0]                 i_wsel1,
    input  logic [DWIDTH-1:0]             i_wdat1,
    input  logic                          i_iss,
    input  logic [AW-1:0]                 i_isel,
    output logic [DWIDTH-1:0]             o_rdat,
    output logic                          o_rbusy
);
    logic w_hit0, w_hit1, w_iss_hit;

    always_comb begin
        w_hit0    = i_we0 && (i_wsel0 == i_rsel);
        w_hit1    = i_we1 && (i_wsel1 == i_rsel);
        w_iss_hit = i_iss && (i_isel == i_rsel);
        o_rdat    = i_regs[i_rsel];
        o_rbusy   = i_pend[i_rsel];
        if (BYPASS != 0) begin
            if (w_hit1)      o_rdat = i_wdat1;
            else if (w_hit0) o_rdat = i_wdat0;
            // A completing write frees the register unless a new producer issues to it now.
            if ((w_hit0 || w_hit1) && !w_iss_hit) o_rbusy = 1'b0;
        end
        if (!i_rst_n) begin
            o_rdat  = '0;
            o_rbusy = 1'b0;
        end
    end
endmodule

module regfile_sb #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic         CLK,
    input  logic         nRST,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][DWIDTH-1:0] r_regs;
    logic [NREGS-1:0]             r_pend;
    logic [NREGS-1:0]             w_pend_nxt;
    logic                         w_we0, w_we1, w_iss;
    logic [NRD-1:0][DWIDTH-1:0]   w_rdat;
    logic [NRD-1:0]               w_rbusy;

    // Writes and issues to register 0 are dropped here, so every consumer sees them as no-ops.
    assign w_we0 = bus.WEN0 && (bus.wsel0 != '0);
    assign w_we1 = bus.WEN1 && (bus.wsel1 != '0);
    assign w_iss = bus.iss  && (bus.isel  != '0);

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we0) w_pend_nxt[bus.wsel0] = 1'b0;
        if (w_we1) w_pend_nxt[bus.wsel1] = 1'b0;
        if (w_iss) w_pend_nxt[bus.isel]  = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_regs <= '0;
            r_pend <= '0;
        end else begin
            if (w_we0) r_regs[bus.wsel0] <= bus.wdat0;
            if (w_we1) r_regs[bus.wsel1] <= bus.wdat1;
            r_pend <= w_pend_nxt;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            regfile_sb_rdport #(
                .DWIDTH (DWIDTH),
                .NREGS  (NREGS),
                .BYPASS (BYPASS)
            ) u_rd (
                .i_rst_n (nRST),
                .i_regs  (r_regs),
                .i_pend  (r_pend),
                .i_rsel  (bus.rsel[k*AW +: AW]),
                .i_we0   (w_we0),
                .i_wsel0 (bus.wsel0),
                .i_wdat0 (bus.wdat0),
                .i_we1   (w_we1),
                .i_wsel1 (bus.wsel1),
                .i_wdat1 (bus.wdat1),
                .i_iss   (w_iss),
                .i_isel  (bus.isel),
                .o_rdat  (w_rdat[k]),
                .o_rbusy (w_rbusy[k])
            );
        end
    endgenerate

    assign bus.rdat  = w_rdat;
    assign bus.rbusy = w_rbusy;
    assign bus.pend  = r_pend;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two DUTs (BYPASS=1 and BYPASS=0) share stimulus; a negedge monitor
// pops expected values queued by the stimulus process and compares them.
module tb_regfile_sb;
    logic CLK;
    logic nRST;

    regfile_sb_if #(.DWIDTH(32), .NREGS(32), .NRD(2)) bus1 ();
    regfile_sb_if #(.DWIDTH(32), .NREGS(32), .NRD(2)) bus0 ();

    regfile_sb #(.DWIDTH(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut1 (
        .CLK (CLK), .nRST (nRST), .bus (bus1.slave)
    );
    regfile_sb #(.DWIDTH(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut0 (
        .CLK (CLK), .nRST (nRST), .bus (bus0.slave)
    );

    // kind: 0 rdat/1 rbusy/2 pend of the bypassing DUT, 3/4/5 the same for the registered DUT
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   nvec  = 0;
    int   nfail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            chk_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = bus1.rdat[e.port*32 +: 32];
                1:       act = {31'b0, bus1.rbusy[e.port]};
                2:       act = bus1.pend;
                3:       act = bus0.rdat[e.port*32 +: 32];
                4:       act = {31'b0, bus0.rbusy[e.port]};
                default: act = bus0.pend;
            endcase
            nvec++;
            if (act !== e.exp) begin
                nfail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] exp, input string name);
        chk_t e;
        e.kind = kind; e.port = port; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic drv(input logic w0, input logic [4:0] s0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] s1, input logic [31:0] d1,
                       input logic is, input logic [4:0] isl,
                       input logic [4:0] r0, input logic [4:0] r1);
        bus1.WEN0 = w0; bus1.wsel0 = s0; bus1.wdat0 = d0;
        bus1.WEN1 = w1; bus1.wsel1 = s1; bus1.wdat1 = d1;
        bus1.iss  = is; bus1.isel  = isl; bus1.rsel = {r1, r0};
        bus0.WEN0 = w0; bus0.wsel0 = s0; bus0.wdat0 = d0;
        bus0.WEN1 = w1; bus0.wsel1 = s1; bus0.wdat1 = d1;
        bus0.iss  = is; bus0.isel  = isl; bus0.rsel = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drv(1, 5, 32'hCAFE, 0, 0, 0, 1, 3, 5, 3);
        step();
        push(0, 0, 32'h0, "reset rdat0");
        push(0, 1, 32'h0, "reset rdat1");
        push(1, 0, 32'h0, "reset rbusy0");
        push(2, 0, 32'h0, "reset pend");
        push(3, 0, 32'h0, "reset rdat0 nb");
        @(negedge CLK);
        #1 idle(5, 3);
        #1 nRST = 1'b1;

        // write r5 and read it in the same cycle
        step(); drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        push(0, 0, 32'hDEADBEEF, "bypass r5");
        push(3, 0, 32'h0,        "nobypass r5 old");
        push(1, 0, 32'h0,        "rbusy r5 wr");
        step(); idle(5, 0);
        push(0, 0, 32'hDEADBEEF, "r5 after");
        push(3, 0, 32'hDEADBEEF, "r5 after nb");
        push(1, 0, 32'h0,        "rbusy r5");
        push(2, 0, 32'h0,        "pend after plain write");

        // dual write to r7, port 1 wins
        step(); drv(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5);
        push(0, 0, 32'h22,       "dual wr bypass");
        push(3, 0, 32'h0,        "dual wr nobypass");
        push(0, 1, 32'hDEADBEEF, "r5 on port1");
        step(); idle(7, 7);
        push(0, 0, 32'h22, "r7 port0");
        push(0, 1, 32'h22, "r7 port1");
        push(3, 1, 32'h22, "r7 port1 nb");

        // r0 is immutable and never pending
        step(); drv(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
        push(0, 0, 32'h0, "r0 same cycle");
        push(1, 0, 32'h0, "r0 rbusy");
        step(); idle(0, 0);
        push(0, 0, 32'h0, "r0 after");
        push(2, 0, 32'h0, "pend r0 iss");

        // issue r3, then complete it with port 1
        step(); drv(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        push(1, 0, 32'h0, "rbusy pre-iss");
        step(); idle(3, 0);
        push(2, 0, 32'h8, "pend r3 set");
        push(1, 0, 32'h1, "rbusy r3");
        push(4, 0, 32'h1, "rbusy r3 nb");
        step(); drv(0, 0, 0, 1, 3, 32'h55, 0, 0, 3, 0);
        push(0, 0, 32'h55, "r3 bypass");
        push(1, 0, 32'h0,  "rbusy r3 cleared");
        push(3, 0, 32'h0,  "r3 nobypass old");
        push(4, 0, 32'h1,  "rbusy r3 nb");
        step(); idle(3, 0);
        push(2, 0, 32'h0,  "pend r3 cleared");
        push(0, 0, 32'h55, "r3 after");
        push(1, 0, 32'h0,  "rbusy r3 after");

        // issue and write r9 together: set wins
        step(); drv(1, 9, 32'hABCD, 0, 0, 0, 1, 9, 9, 0);
        push(0, 0, 32'hABCD, "r9 bypass");
        push(1, 0, 32'h0,    "rbusy r9 iss+wr");
        step(); idle(9, 0);
        push(2, 0, 32'h200,  "pend r9 set wins");
        push(0, 0, 32'hABCD, "r9 after");
        push(1, 0, 32'h1,    "rbusy r9");

        // fill r1..r31, then mark r2 and r4 pending
        for (int n = 1; n < 32; n++) begin
            step(); drv(1, 5'(n), 32'h1000 + 32'(n), 0, 0, 0, 0, 0, 0, 0);
        end
        step(); drv(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 1, 4, 31, 2);
        push(0, 0, 32'h101F, "r31 fill");
        push(1, 1, 32'h1,    "rbusy r2");
        step(); idle(1, 4);
        push(2, 0, 32'h14,   "pend r2 r4");
        push(5, 0, 32'h14,   "pend r2 r4 nb");
        push(0, 0, 32'h1001, "r1 fill");
        push(1, 1, 32'h1,    "rbusy r4");

        // async reset pulse between edges with a write and issue held
        step(); nRST = 1'b0; drv(1, 6, 32'h77, 0, 0, 0, 1, 8, 31, 2);
        push(0, 0, 32'h0, "rst pulse rdat0");
        push(0, 1, 32'h0, "rst pulse rdat1");
        push(1, 1, 32'h0, "rst pulse rbusy1");
        push(2, 0, 32'h0, "rst pulse pend");
        push(3, 0, 32'h0, "rst pulse rdat0 nb");
        @(negedge CLK);
        #1 idle(6, 31);
        #1 nRST = 1'b1;
        step(); idle(6, 31);
        push(0, 0, 32'h0, "r6 not written");
        push(0, 1, 32'h0, "r31 cleared");
        push(2, 0, 32'h0, "pend after rst");
        push(5, 0, 32'h0, "pend after rst nb");

        step();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            nfail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
